bus_port: RTL and testbench
===========================

BUS_PORT -- requirements
Module: bus_port

Interface
REQ-001 Parameter WD_LIMIT, default 1023: maximum cycles in REQ+WAIT before a watchdog abort.
REQ-002 Parameter AMO_OPCODE, default 7'b0101111: instruction opcode [6:0] that marks an atomic access.
REQ-003 Ports CLK, in, 1: single clock, all state on rising edge; RST_X, in, 1: asynchronous, active-low reset.
REQ-004 Core-side ports:
- c_dram_le, in, 1: dram load strobe.
- c_dram_we_t, in, 1: dram store strobe.
- c_data_le, in, 1: data load strobe.
- c_data_we, in, 1: data store strobe.
- c_dram_addr, in, 32; c_dram_wdata, in, 32; c_dram_ctrl, in, 3.
- c_mem_paddr, in, 32; c_data_wdata, in, 32.
- c_ir, in, 32: current instruction.
REQ-005 Core-side outputs:
- c_dram_busy, out, 1; c_data_busy, out, 1.
- c_dram_odata, out, 32; c_data_rdata, out, 32.
REQ-006 Arbiter-side outputs:
- b_req, out, 1; b_lock, out, 1.
- b_dram_le, b_dram_we_t, b_data_le, b_data_we, out, 1 each.
- b_dram_addr, b_dram_wdata, b_mem_paddr, b_data_wdata, out, 32 each; b_dram_ctrl, out, 3.
REQ-007 Arbiter-side inputs: b_ack, in, 1, one-cycle accept pulse; b_done, in, 1, one-cycle completion pulse; b_dram_odata, in, 32; b_data_rdata, in, 32.
REQ-008 Status outputs: err_overlap, out, 1, sticky; err_timeout, out, 1, sticky; req_count, out, 16, completed transactions.

Function
REQ-009 FSM states: IDLE, REQ, WAIT; all b_* fields and response data are registered outputs.
REQ-010 IDLE, any strobe high: on that edge, capture all four strobes and all address, data and ctrl fields into b_*; set b_req=1.
REQ-011 Same IDLE edge: c_dram_busy = c_dram_le|c_dram_we_t; c_data_busy = c_data_le|c_data_we; go to REQ.
REQ-012 Dram and data strobes in the same cycle form one transaction; both busy bits are set.
REQ-013 IDLE capture with c_ir[6:0]==AMO_OPCODE: set b_lock=1.
REQ-014 b_lock clears on b_done of a transaction whose captured b_dram_we_t or b_data_we is 1; it stays 1 across the intervening load.
REQ-015 REQ: hold b_req and all fields stable until b_ack; on b_ack, b_req=0 and go to WAIT.
REQ-016 b_ack and b_done in the same cycle while in REQ: complete directly, as in REQ-017.
REQ-017 Completion (WAIT, or REQ per REQ-016, with b_done=1):
- Latch b_dram_odata into c_dram_odata and b_data_rdata into c_data_rdata.
- Clear both busy bits and all four b_* strobes.
- req_count += 1, wrapping 16'hFFFF -> 0.
- Go to IDLE.
- Total latency: busy falls on the edge that samples b_done.
REQ-018 b_done or b_ack in IDLE, or b_done in REQ without b_ack: ignored, no state change.
REQ-019 Any strobe while not IDLE: ignored; set err_overlap=1; captured fields unchanged.
REQ-020 Watchdog counter, 16 bits:
- Clears on entry to REQ; increments each cycle in REQ or WAIT.
- When it equals WD_LIMIT with no b_done: set err_timeout=1; clear b_req, strobes, busy bits and b_lock; go to IDLE.
- Response data is not updated and req_count does not increment.
REQ-021 c_dram_odata and c_data_rdata hold their last latched values until the next completion.
REQ-022 In IDLE, b_dram_addr, b_dram_wdata, b_dram_ctrl, b_mem_paddr and b_data_wdata hold their last captured values.

Reset
REQ-023 RST_X=0 immediately, without waiting for CLK:
- FSM goes to IDLE.
- All outputs go to 0, including b_req, b_lock, busy bits, data, err flags, req_count and the watchdog counter.
REQ-024 Reset mid-transaction abandons the transaction; no b_req is reissued after reset release.
REQ-025 Operation resumes on the first rising CLK edge with RST_X=1.

Verification
REQ-026 c_dram_le=1 for one cycle, addr=32'h8000_0010; b_ack 2 cycles later; b_done with odata=32'hDEAD_BEEF 3 cycles after that:
- b_req high exactly 2 cycles.
- c_dram_busy falls on the b_done edge.
- c_dram_odata=32'hDEAD_BEEF; req_count=1.
REQ-027 AMO sequence, c_ir[6:0]=7'b0101111: load, then store.
- b_lock=1 from the load capture through the store's b_done, then 0.
- req_count=2.
REQ-028 c_data_we pulsed while in WAIT:
- err_overlap=1.
- b_mem_paddr unchanged.
- The pending transaction still completes normally.
REQ-029 Request, then b_ack, then no b_done, with WD_LIMIT=8:
- err_timeout=1 after 8 cycles in REQ+WAIT.
- Busy bits 0; state IDLE; req_count unchanged.
REQ-030 RST_X asserted low mid-WAIT, asynchronous to CLK:
- All outputs 0 before the next edge.
- No b_req after release until a new strobe.
REQ-031 b_ack and b_done in the same cycle as the first REQ cycle: one-cycle completion; req_count goes 16'hFFFF -> 0.

Source files
------------

// File: rtl/bus_port_if.sv
// Arbiter-side bus between a core port and the shared-bus arbiter.
// The master side (bus_port) issues requests; the slave side (arbiter) acknowledges and completes them.
interface bus_port_if;
   logic        b_req;
   logic        b_lock;
   logic        b_dram_le;
   logic        b_dram_we_t;
   logic        b_data_le;
   logic        b_data_we;
   logic [31:0] b_dram_addr;
   logic [31:0] b_dram_wdata;
   logic [2:0]  b_dram_ctrl;
   logic [31:0] b_mem_paddr;
   logic [31:0] b_data_wdata;
   logic        b_ack;
   logic        b_done;
   logic [31:0] b_dram_odata;
   logic [31:0] b_data_rdata;

   modport master (
      output b_req, b_lock, b_dram_le, b_dram_we_t, b_data_le, b_data_we,
      output b_dram_addr, b_dram_wdata, b_dram_ctrl, b_mem_paddr, b_data_wdata,
      input  b_ack, b_done, b_dram_odata, b_data_rdata
   );

   modport slave (
      input  b_req, b_lock, b_dram_le, b_dram_we_t, b_data_le, b_data_we,
      input  b_dram_addr, b_dram_wdata, b_dram_ctrl, b_mem_paddr, b_data_wdata,
      output b_ack, b_done, b_dram_odata, b_data_rdata
   );
endinterface

// File: rtl/bus_port.sv
// Core-to-arbiter bus port: captures one core access, holds it on the bus until the arbiter
// completes it, returns response data, and aborts via a watchdog if completion never comes.
module bus_port #(
   parameter int unsigned WD_LIMIT   = 1023,
   parameter logic [6:0]  AMO_OPCODE = 7'b0101111
) (
   input  logic        CLK,
   input  logic        RST_X,
   input  logic        c_dram_le,
   input  logic        c_dram_we_t,
   input  logic        c_data_le,
   input  logic        c_data_we,
   input  logic [31:0] c_dram_addr,
   input  logic [31:0] c_dram_wdata,
   input  logic [2:0]  c_dram_ctrl,
   input  logic [31:0] c_mem_paddr,
   input  logic [31:0] c_data_wdata,
   input  logic [31:0] c_ir,
   output logic        c_dram_busy,
   output logic        c_data_busy,
   output logic [31:0] c_dram_odata,
   output logic [31:0] c_data_rdata,
   bus_port_if.master  bus,
   output logic        err_overlap,
   output logic        err_timeout,
   output logic [15:0] req_count
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   localparam logic [15:0] WD_LIM16 = 16'(WD_LIMIT);

   state_t      state, state_nxt;
   logic [15:0] wd_cnt;
   logic        any_stb;
   logic        is_amo;
   logic        wd_hit;
   logic        capture, accept, complete, abort;
   logic        unused_ir;

   assign any_stb   = c_dram_le | c_dram_we_t | c_data_le | c_data_we;
   assign is_amo    = (c_ir[6:0] == AMO_OPCODE);
   assign unused_ir = ^c_ir[31:7];
   // Abort on the edge that closes the WD_LIMIT-th cycle spent in REQ+WAIT.
   assign wd_hit    = ((wd_cnt + 16'd1) == WD_LIM16);

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (capture)              state_nxt = REQ;
      else if (complete | abort) state_nxt = IDLE;
      else if (accept)          state_nxt = WAIT;
   end

   // b_done outranks the watchdog; b_ack alone only advances REQ to WAIT.
   always_comb begin
      capture  = 1'b0;
      accept   = 1'b0;
      complete = 1'b0;
      abort    = 1'b0;
      unique case (state)
         IDLE: capture = any_stb;
         REQ: begin
            if (bus.b_ack && bus.b_done) complete = 1'b1;
            else if (wd_hit)             abort    = 1'b1;
            else if (bus.b_ack)          accept   = 1'b1;
         end
         WAIT: begin
            if (bus.b_done)  complete = 1'b1;
            else if (wd_hit) abort    = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         bus.b_req        <= 1'b0;
         bus.b_lock       <= 1'b0;
         bus.b_dram_le    <= 1'b0;
         bus.b_dram_we_t  <= 1'b0;
         bus.b_data_le    <= 1'b0;
         bus.b_data_we    <= 1'b0;
         bus.b_dram_addr  <= '0;
         bus.b_dram_wdata <= '0;
         bus.b_dram_ctrl  <= '0;
         bus.b_mem_paddr  <= '0;
         bus.b_data_wdata <= '0;
         c_dram_busy      <= 1'b0;
         c_data_busy      <= 1'b0;
         c_dram_odata     <= '0;
         c_data_rdata     <= '0;
         err_overlap      <= 1'b0;
         err_timeout      <= 1'b0;
         req_count        <= '0;
         wd_cnt           <= '0;
      end else begin
         if ((state != IDLE) && any_stb) err_overlap <= 1'b1;

         if (capture) begin
            bus.b_req        <= 1'b1;
            bus.b_dram_le    <= c_dram_le;
            bus.b_dram_we_t  <= c_dram_we_t;
            bus.b_data_le    <= c_data_le;
            bus.b_data_we    <= c_data_we;
            bus.b_dram_addr  <= c_dram_addr;
            bus.b_dram_wdata <= c_dram_wdata;
            bus.b_dram_ctrl  <= c_dram_ctrl;
            bus.b_mem_paddr  <= c_mem_paddr;
            bus.b_data_wdata <= c_data_wdata;
            c_dram_busy      <= c_dram_le | c_dram_we_t;
            c_data_busy      <= c_data_le | c_data_we;
            if (is_amo) bus.b_lock <= 1'b1;
         end else if (complete) begin
            bus.b_req       <= 1'b0;
            bus.b_dram_le   <= 1'b0;
            bus.b_dram_we_t <= 1'b0;
            bus.b_data_le   <= 1'b0;
            bus.b_data_we   <= 1'b0;
            c_dram_busy     <= 1'b0;
            c_data_busy     <= 1'b0;
            c_dram_odata    <= bus.b_dram_odata;
            c_data_rdata    <= bus.b_data_rdata;
            req_count       <= req_count + 16'd1;
            // The lock spans an atomic load/store pair; only the store's completion releases it.
            if (bus.b_dram_we_t || bus.b_data_we) bus.b_lock <= 1'b0;
         end else if (abort) begin
            bus.b_req       <= 1'b0;
            bus.b_lock      <= 1'b0;
            bus.b_dram_le   <= 1'b0;
            bus.b_dram_we_t <= 1'b0;
            bus.b_data_le   <= 1'b0;
            bus.b_data_we   <= 1'b0;
            c_dram_busy     <= 1'b0;
            c_data_busy     <= 1'b0;
            err_timeout     <= 1'b1;
         end else if (accept) begin
            bus.b_req <= 1'b0;
         end

         if (capture)              wd_cnt <= '0;
         else if (state != IDLE)   wd_cnt <= wd_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_bus_port.sv
// Scoreboard bench for bus_port: expected responses are queued when a transaction is issued
// and compared whenever the completed-transaction counter advances.
module tb_bus_port;
   localparam int unsigned WDL = 8;

   logic        CLK = 1'b0;
   logic        RST_X;
   logic        c_dram_le, c_dram_we_t, c_data_le, c_data_we;
   logic [31:0] c_dram_addr, c_dram_wdata, c_mem_paddr, c_data_wdata, c_ir;
   logic [2:0]  c_dram_ctrl;
   logic        c_dram_busy, c_data_busy;
   logic [31:0] c_dram_odata, c_data_rdata;
   logic        err_overlap, err_timeout;
   logic [15:0] req_count;

   bus_port_if bif();

   bus_port #(.WD_LIMIT(WDL), .AMO_OPCODE(7'b0101111)) dut (
      .CLK(CLK), .RST_X(RST_X),
      .c_dram_le(c_dram_le), .c_dram_we_t(c_dram_we_t),
      .c_data_le(c_data_le), .c_data_we(c_data_we),
      .c_dram_addr(c_dram_addr), .c_dram_wdata(c_dram_wdata), .c_dram_ctrl(c_dram_ctrl),
      .c_mem_paddr(c_mem_paddr), .c_data_wdata(c_data_wdata), .c_ir(c_ir),
      .c_dram_busy(c_dram_busy), .c_data_busy(c_data_busy),
      .c_dram_odata(c_dram_odata), .c_data_rdata(c_data_rdata),
      .bus(bif),
      .err_overlap(err_overlap), .err_timeout(err_timeout), .req_count(req_count)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] od;
      logic [31:0] rd;
      logic [15:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] exp_cnt;
   logic [15:0] prev_cnt = 16'd0;
   bit          sb_skip = 1'b0;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Completion monitor: every advance of req_count consumes one expected response.
   always @(posedge CLK) begin
      #1;
      if (!RST_X) begin
         prev_cnt = 16'd0;
      end else if (req_count !== prev_cnt) begin
         if (!sb_skip) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sb_odata", c_dram_odata, e.od);
               check("sb_rdata", c_data_rdata, e.rd);
               check("sb_count", {16'd0, req_count}, {16'd0, e.cnt});
               check("sb_busy", {30'd0, c_dram_busy, c_data_busy}, 32'd0);
            end
         end
         prev_cnt = req_count;
      end
   end

   task automatic xact(input string tag, input logic [3:0] stb, input logic [31:0] ir,
                       input int ack_dly, input int done_dly,
                       input logic [31:0] od, input logic [31:0] rd,
                       input logic lk_mid, input logic lk_end);
      {c_dram_le, c_dram_we_t, c_data_le, c_data_we} = stb;
      c_ir = ir;
      exp_cnt = exp_cnt + 16'd1;
      exp_q.push_back(exp_t'{od, rd, exp_cnt});
      tick();
      {c_dram_le, c_dram_we_t, c_data_le, c_data_we} = 4'b0000;
      check({tag, "_busy"}, {30'd0, c_dram_busy, c_data_busy},
            {30'd0, stb[3] | stb[2], stb[1] | stb[0]});
      check({tag, "_req"}, 32'(bif.b_req), 32'd1);
      check({tag, "_lock"}, 32'(bif.b_lock), 32'(lk_mid));
      repeat (ack_dly) begin
         tick();
         check({tag, "_req_hold"}, 32'(bif.b_req), 32'd1);
         check({tag, "_lock_hold"}, 32'(bif.b_lock), 32'(lk_mid));
      end
      bif.b_ack = 1'b1;
      if (done_dly == 0) begin
         bif.b_done = 1'b1;
         bif.b_dram_odata = od;
         bif.b_data_rdata = rd;
      end
      tick();
      bif.b_ack  = 1'b0;
      bif.b_done = 1'b0;
      if (done_dly > 0) begin
         check({tag, "_req_drop"}, 32'(bif.b_req), 32'd0);
         repeat (done_dly - 1) begin
            tick();
            check({tag, "_wait_busy"}, 32'(c_dram_busy | c_data_busy), 32'd1);
            check({tag, "_wait_lock"}, 32'(bif.b_lock), 32'(lk_mid));
         end
         bif.b_done = 1'b1;
         bif.b_dram_odata = od;
         bif.b_data_rdata = rd;
         tick();
         bif.b_done = 1'b0;
      end
      check({tag, "_done_busy"}, {30'd0, c_dram_busy, c_data_busy}, 32'd0);
      check({tag, "_done_req"}, 32'(bif.b_req), 32'd0);
      check({tag, "_done_lock"}, 32'(bif.b_lock), 32'(lk_end));
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      {c_dram_le, c_dram_we_t, c_data_le, c_data_we} = 4'b0000;
      c_dram_addr = '0; c_dram_wdata = '0; c_dram_ctrl = '0;
      c_mem_paddr = '0; c_data_wdata = '0; c_ir = '0;
      bif.b_ack = 1'b0; bif.b_done = 1'b0;
      bif.b_dram_odata = '0; bif.b_data_rdata = '0;
      exp_cnt = 16'd0;
      RST_X = 1'b1;

      // Asynchronous reset, observed before the first clock edge
      #2 RST_X = 1'b0;
      #1;
      check("rst_req", 32'(bif.b_req), 32'd0);
      check("rst_lock", 32'(bif.b_lock), 32'd0);
      check("rst_busy", {30'd0, c_dram_busy, c_data_busy}, 32'd0);
      check("rst_count", {16'd0, req_count}, 32'd0);
      check("rst_errs", {30'd0, err_overlap, err_timeout}, 32'd0);
      check("rst_odata", c_dram_odata, 32'd0);
      repeat (2) @(posedge CLK);
      @(negedge CLK) RST_X = 1'b1;
      tick();
      check("idle_req", 32'(bif.b_req), 32'd0);

      // Single dram load: ack in the 2nd REQ cycle, done 3 cycles later
      c_dram_addr = 32'h8000_0010; c_dram_wdata = 32'h1234_5678; c_dram_ctrl = 3'd2;
      xact("dram_ld", 4'b1000, 32'h0, 1, 3, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
      check("addr_hold", bif.b_dram_addr, 32'h8000_0010);
      check("ctrl_hold", 32'(bif.b_dram_ctrl), 32'd2);
      check("dram_le_clr", 32'(bif.b_dram_le), 32'd0);
      check("dram_ld_cnt", {16'd0, req_count}, 32'd1);

      // Atomic load/store pair holds the lock throughout
      c_mem_paddr = 32'h0000_4000;
      xact("amo_ld", 4'b0010, 32'h0000_002F, 0, 2, 32'hDEAD_BEEF, 32'hCAFE_0001, 1'b1, 1'b1);
      c_data_wdata = 32'h5555_AAAA;
      xact("amo_st", 4'b0001, 32'h0000_002F, 1, 1, 32'hDEAD_BEEF, 32'hCAFE_0002, 1'b1, 1'b0);
      check("amo_cnt", {16'd0, req_count}, 32'd3);
      check("no_overlap_yet", 32'(err_overlap), 32'd0);

      // Overlapping store strobe while waiting for completion
      c_mem_paddr = 32'h1111_0000; c_data_wdata = 32'h0BAD_F00D; c_ir = '0;
      c_data_we = 1'b1;
      exp_cnt = exp_cnt + 16'd1;
      exp_q.push_back(exp_t'{32'h0000_0C0C, 32'h0000_0D0D, exp_cnt});
      tick();
      c_data_we = 1'b0;
      bif.b_ack = 1'b1;
      tick();
      bif.b_ack = 1'b0;
      c_data_we = 1'b1; c_mem_paddr = 32'h2222_0000;
      tick();
      c_data_we = 1'b0;
      check("ovl_flag", 32'(err_overlap), 32'd1);
      check("ovl_paddr", bif.b_mem_paddr, 32'h1111_0000);
      check("ovl_busy", 32'(c_data_busy), 32'd1);
      bif.b_done = 1'b1; bif.b_dram_odata = 32'h0000_0C0C; bif.b_data_rdata = 32'h0000_0D0D;
      tick();
      bif.b_done = 1'b0;
      check("ovl_done_busy", 32'(c_data_busy), 32'd0);

      // Watchdog abort: ack, then no done for WDL cycles in REQ+WAIT
      bif.b_dram_odata = 32'hFFFF_0000; bif.b_data_rdata = 32'hFFFF_1111;
      c_dram_we_t = 1'b1;
      tick();
      c_dram_we_t = 1'b0;
      bif.b_ack = 1'b1;
      tick();
      bif.b_ack = 1'b0;
      repeat (WDL - 2) tick();
      check("wd_not_yet", 32'(err_timeout), 32'd0);
      check("wd_busy_yet", 32'(c_dram_busy), 32'd1);
      tick();
      check("wd_flag", 32'(err_timeout), 32'd1);
      check("wd_busy", {30'd0, c_dram_busy, c_data_busy}, 32'd0);
      check("wd_req", 32'(bif.b_req), 32'd0);
      check("wd_stb", 32'(bif.b_dram_we_t), 32'd0);
      check("wd_count", {16'd0, req_count}, {16'd0, exp_cnt});
      check("wd_odata_hold", c_dram_odata, 32'h0000_0C0C);
      check("wd_rdata_hold", c_data_rdata, 32'h0000_0D0D);
      xact("post_wd", 4'b1000, 32'h0, 0, 1, 32'h7777_0001, 32'h7777_0002, 1'b0, 1'b0);

      // Asynchronous reset mid-WAIT of a locked transaction
      c_dram_le = 1'b1; c_ir = 32'h0000_002F;
      tick();
      c_dram_le = 1'b0;
      check("pre_rst_lock", 32'(bif.b_lock), 32'd1);
      bif.b_ack = 1'b1;
      tick();
      bif.b_ack = 1'b0;
      #2 RST_X = 1'b0;
      #1;
      check("mrst_req", 32'(bif.b_req), 32'd0);
      check("mrst_lock", 32'(bif.b_lock), 32'd0);
      check("mrst_busy", {30'd0, c_dram_busy, c_data_busy}, 32'd0);
      check("mrst_odata", c_dram_odata, 32'd0);
      check("mrst_rdata", c_data_rdata, 32'd0);
      check("mrst_errs", {30'd0, err_overlap, err_timeout}, 32'd0);
      check("mrst_count", {16'd0, req_count}, 32'd0);
      check("mrst_addr", bif.b_dram_addr, 32'd0);
      check("mrst_stb", 32'(bif.b_dram_le), 32'd0);
      exp_cnt = 16'd0;
      repeat (2) @(posedge CLK);
      @(negedge CLK) RST_X = 1'b1;
      repeat (3) begin
         tick();
         check("rel_noreq", 32'(bif.b_req), 32'd0);
      end
      bif.b_done = 1'b1;
      tick();
      bif.b_done = 1'b0;
      check("idle_done_ign", {16'd0, req_count}, 32'd0);

      // Counter wrap with a one-cycle completion of a combined dram+data access
      sb_skip = 1'b1;
      force dut.req_count = 16'hFFFF;
      #1 release dut.req_count;
      tick();
      tick();
      sb_skip = 1'b0;
      exp_cnt = 16'hFFFF;
      check("pre_wrap", {16'd0, req_count}, 32'h0000_FFFF);
      xact("wrap", 4'b1010, 32'h0, 0, 0, 32'hA5A5_0001, 32'h5A5A_0002, 1'b0, 1'b0);
      check("wrap_cnt", {16'd0, req_count}, 32'd0);

      tick();
      check("sb_left", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
